// File: rtl/jt10_adpcm_pkg.sv
// Shared types and constants for the ADPCM-A mixer slice.
package jt10_adpcm_pkg;

  localparam int unsigned NCH   = 6;
  localparam int unsigned ACC_W = 19;

  localparam logic [NCH-1:0] SLOT0     = 6'b000001;
  localparam logic [NCH-1:0] ALL_SLOTS = 6'b111111;

  // Signed round accumulator; six full-scale samples fit without overflow.
  typedef logic signed [ACC_W-1:0] acc_t;

  // True when exactly one bit of the slot vector is set.
  function automatic logic is_onehot(input logic [NCH-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

endpackage

// File: rtl/jt10_adpcma_limit.sv
// Output limiter: arithmetic shift of a round sum, then reduction to 16 bits.
// Build option: define JT10_ADPCMA_SAT_EN to clamp to the 16-bit signed range;
// without it the low 16 bits are taken (two's-complement wrap).
module jt10_adpcma_limit
  import jt10_adpcm_pkg::*;
#(
  parameter int unsigned OUT_SHIFT = 0
) (
  input  logic signed [ACC_W-1:0] acc,
  output logic        [15:0]      pcm
);

  acc_t shifted;

  // Scale the round sum before limiting.
  always_comb begin
    shifted = acc >>> OUT_SHIFT;
  end

`ifdef JT10_ADPCMA_SAT_EN
  localparam acc_t PcmMax = acc_t'(32767);
  localparam acc_t PcmMin = acc_t'(-32768);

  // Clamp to the representable output range.
  always_comb begin
    pcm = shifted[15:0];
    if (shifted > PcmMax) begin
      pcm = 16'h7fff;
    end else if (shifted < PcmMin) begin
      pcm = 16'h8000;
    end
  end
`else
  logic unused_hi;
  assign unused_hi = ^shifted[ACC_W-1:16];

  // Plain truncation; upper bits are dropped.
  always_comb begin
    pcm = shifted[15:0];
  end
`endif

endmodule

// File: rtl/jt10_adpcma_mix.sv
// ADPCM-A stereo mixer: accumulates six attenuated channel samples per round into
// left/right sums using per-slot pan bits, and publishes a 16-bit stereo sample
// once each complete round, at the ch0 slot that opens the following round.
// Build option: JT10_ADPCMA_SAT_EN selects clamping in the output limiter.
module jt10_adpcma_mix
  import jt10_adpcm_pkg::*;
#(
  parameter int unsigned OUT_SHIFT = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cen,
  input  logic [5:0]  cur_ch,
  input  logic [5:0]  ch_on,
  input  logic        sample,
  input  logic [1:0]  lr,
  input  logic [15:0] pcm_in,
  output logic [15:0] pcm_l,
  output logic [15:0] pcm_r,
  output logic        snd_sample
);

  acc_t           acc_l_q, acc_l_d;
  acc_t           acc_r_q, acc_r_d;
  logic [NCH-1:0] mask_q, mask_d;
  logic [15:0]    pcm_l_q, pcm_l_d;
  logic [15:0]    pcm_r_q, pcm_r_d;
  logic           snd_q;

  logic           slot_valid;
  logic           slot_first;
  logic           publish;
  acc_t           contrib;
  acc_t           base_l, base_r;
  logic [15:0]    lim_l, lim_r;

  // Slot qualification and this slot's signed contribution.
  always_comb begin
    slot_valid = cen & sample & is_onehot(cur_ch);
    slot_first = slot_valid && (cur_ch == SLOT0);
    // Only a round that saw every slot is published.
    publish    = slot_first && (mask_q == ALL_SLOTS);
    if ((ch_on & cur_ch) != '0) begin
      contrib = {{(ACC_W-16){pcm_in[15]}}, pcm_in};
    end else begin
      contrib = '0;
    end
  end

  // Accumulator and slot-mask next state; ch0 reloads instead of adding.
  always_comb begin
    acc_l_d = acc_l_q;
    acc_r_d = acc_r_q;
    mask_d  = mask_q;
    base_l  = slot_first ? acc_t'(0) : acc_l_q;
    base_r  = slot_first ? acc_t'(0) : acc_r_q;
    if (slot_valid) begin
      acc_l_d = base_l + (lr[1] ? contrib : acc_t'(0));
      acc_r_d = base_r + (lr[0] ? contrib : acc_t'(0));
      mask_d  = slot_first ? SLOT0 : (mask_q | cur_ch);
    end
  end

  jt10_adpcma_limit #(
    .OUT_SHIFT (OUT_SHIFT)
  ) u_limit_l (
    .acc (acc_l_q),
    .pcm (lim_l)
  );

  jt10_adpcma_limit #(
    .OUT_SHIFT (OUT_SHIFT)
  ) u_limit_r (
    .acc (acc_r_q),
    .pcm (lim_r)
  );

  // Output hold registers take the finished round only on publish.
  always_comb begin
    pcm_l_d = publish ? lim_l : pcm_l_q;
    pcm_r_d = publish ? lim_r : pcm_r_q;
  end

  // State registers; snd_q follows publish so it lasts a single clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_l_q <= '0;
      acc_r_q <= '0;
      mask_q  <= '0;
      pcm_l_q <= '0;
      pcm_r_q <= '0;
      snd_q   <= 1'b0;
    end else begin
      acc_l_q <= acc_l_d;
      acc_r_q <= acc_r_d;
      mask_q  <= mask_d;
      pcm_l_q <= pcm_l_d;
      pcm_r_q <= pcm_r_d;
      snd_q   <= publish;
    end
  end

  assign pcm_l      = pcm_l_q;
  assign pcm_r      = pcm_r_q;
  assign snd_sample = snd_q;

endmodule

// File: tb/tb_jt10_adpcma_mix.sv
// Self-checking bench for jt10_adpcma_mix. Two instances share stimulus:
// dut0 with OUT_SHIFT=0 and dut1 with OUT_SHIFT=1. Expected stereo samples are
// pushed when a complete round is driven and popped on each snd_sample pulse.
module tb_jt10_adpcma_mix;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cen;
  logic [5:0]  cur_ch;
  logic [5:0]  ch_on;
  logic        sample;
  logic [1:0]  lr;
  logic [15:0] pcm_in;
  logic [15:0] pcm_l0, pcm_r0, pcm_l1, pcm_r1;
  logic        snd0, snd1;

  int errors = 0;
  int checks = 0;

  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic [31:0] e0, e1;
  logic [15:0] last_l0, last_r0, last_l1, last_r1;

  logic [5:0]  r_on;
  logic [1:0]  r_lr[6];
  logic [15:0] r_pcm[6];

  always #5 clk = ~clk;

  jt10_adpcma_mix #(.OUT_SHIFT(0)) dut0 (
    .clk        (clk),
    .rst_n      (rst_n),
    .cen        (cen),
    .cur_ch     (cur_ch),
    .ch_on      (ch_on),
    .sample     (sample),
    .lr         (lr),
    .pcm_in     (pcm_in),
    .pcm_l      (pcm_l0),
    .pcm_r      (pcm_r0),
    .snd_sample (snd0)
  );

  jt10_adpcma_mix #(.OUT_SHIFT(1)) dut1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .cen        (cen),
    .cur_ch     (cur_ch),
    .ch_on      (ch_on),
    .sample     (sample),
    .lr         (lr),
    .pcm_in     (pcm_in),
    .pcm_l      (pcm_l1),
    .pcm_r      (pcm_r1),
    .snd_sample (snd1)
  );

  // Reference limiter working on plain integers.
  function automatic logic [15:0] model_limit(input int sum, input int sh);
    int s;
    s = sum >>> sh;
`ifdef JT10_ADPCMA_SAT_EN
    if (s > 32767) s = 32767;
    else if (s < -32768) s = -32768;
`endif
    return s[15:0];
  endfunction

  // Scoreboard consumer: each clk with snd_sample high must match one pending round.
  always @(negedge clk) begin
    if (rst_n) begin
      if (snd0) begin
        checks++;
        if (q0.size() == 0) begin
          errors++;
          $display("FAIL dut0_pulse: snd_sample=1 required no pulse (nothing pending)");
        end else begin
          e0 = q0.pop_front();
          if ({pcm_l0, pcm_r0} !== e0) begin
            errors++;
            $display("FAIL dut0_mix: got l=%h r=%h required l=%h r=%h",
                     pcm_l0, pcm_r0, e0[31:16], e0[15:0]);
          end
        end
      end
      if (snd1) begin
        checks++;
        if (q1.size() == 0) begin
          errors++;
          $display("FAIL dut1_pulse: snd_sample=1 required no pulse (nothing pending)");
        end else begin
          e1 = q1.pop_front();
          if ({pcm_l1, pcm_r1} !== e1) begin
            errors++;
            $display("FAIL dut1_mix: got l=%h r=%h required l=%h r=%h",
                     pcm_l1, pcm_r1, e1[31:16], e1[15:0]);
          end
        end
      end
    end
  end

  // One cen-qualified slot followed by an idle clk.
  task automatic drive_slot(input logic [5:0] ch, input logic [5:0] on, input logic [1:0] l,
                            input logic [15:0] p, input logic s);
    @(negedge clk);
    cur_ch = ch;
    ch_on  = on;
    lr     = l;
    pcm_in = p;
    sample = s;
    cen    = 1'b1;
    @(negedge clk);
    cen    = 1'b0;
    sample = 1'b0;
    @(negedge clk);
  endtask

  task automatic set_all(input logic [5:0] on, input logic [1:0] l, input logic [15:0] p);
    r_on = on;
    for (int i = 0; i < 6; i++) begin
      r_lr[i]  = l;
      r_pcm[i] = p;
    end
  endtask

  // Drive ch0..ch5 from the r_* tables; skipped slots have sample low.
  task automatic run_round(input logic [5:0] skip, input bit bad_mid);
    int sl, sr, c;
    logic [5:0] ch;
    sl = 0;
    sr = 0;
    for (int i = 0; i < 6; i++) begin
      if (bad_mid && i == 3) begin
        drive_slot(6'b000011, 6'h3f, 2'b11, 16'd5000, 1'b1);
        drive_slot(6'b000000, 6'h3f, 2'b11, 16'd4000, 1'b1);
      end
      ch = 6'(1 << i);
      drive_slot(ch, r_on, r_lr[i], r_pcm[i], !skip[i]);
      if (!skip[i] && r_on[i]) begin
        c = int'($signed(r_pcm[i]));
        if (r_lr[i][1]) sl += c;
        if (r_lr[i][0]) sr += c;
      end
    end
    if (skip == '0) begin
      last_l0 = model_limit(sl, 0);
      last_r0 = model_limit(sr, 0);
      last_l1 = model_limit(sl, 1);
      last_r1 = model_limit(sr, 1);
      q0.push_back({last_l0, last_r0});
      q1.push_back({last_l1, last_r1});
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cen = 1'b0; cur_ch = '0; ch_on = '0; sample = 1'b0; lr = '0; pcm_in = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({pcm_l0, pcm_r0, snd0} !== 33'd0) begin
      errors++;
      $display("FAIL reset_dut0: got l=%h r=%h snd=%b required 0 0 0", pcm_l0, pcm_r0, snd0);
    end
    checks++;
    if ({pcm_l1, pcm_r1, snd1} !== 33'd0) begin
      errors++;
      $display("FAIL reset_dut1: got l=%h r=%h snd=%b required 0 0 0", pcm_l1, pcm_r1, snd1);
    end
    last_l0 = '0; last_r0 = '0; last_l1 = '0; last_r1 = '0;
  endtask

  task automatic test_all_on();
    set_all(6'h3f, 2'b11, 16'd1000);
    run_round(6'b0, 1'b0);
  endtask

  task automatic test_pan();
    set_all(6'b001001, 2'b11, 16'd1234);
    r_lr[0]  = 2'b10;
    r_pcm[0] = -16'sd500;
    r_lr[3]  = 2'b01;
    r_pcm[3] = 16'd700;
    run_round(6'b0, 1'b0);
  endtask

  // Six full-scale slots: 196602 clamps to 7FFF, or wraps to its low 16 bits.
  task automatic test_sat();
    set_all(6'h3f, 2'b11, 16'd32767);
    run_round(6'b0, 1'b0);
  endtask

  task automatic test_skip();
    set_all(6'h3f, 2'b11, 16'd100);
    run_round(6'b000100, 1'b0);
    drive_slot(6'b000001, 6'h3f, 2'b11, 16'd100, 1'b1);
    repeat (2) @(negedge clk);
    checks++;
    if ({pcm_l0, pcm_r0} !== {last_l0, last_r0}) begin
      errors++;
      $display("FAIL skip_hold_dut0: got l=%h r=%h required l=%h r=%h",
               pcm_l0, pcm_r0, last_l0, last_r0);
    end
    checks++;
    if ({pcm_l1, pcm_r1} !== {last_l1, last_r1}) begin
      errors++;
      $display("FAIL skip_hold_dut1: got l=%h r=%h required l=%h r=%h",
               pcm_l1, pcm_r1, last_l1, last_r1);
    end
  endtask

  task automatic test_reset_mid();
    logic [5:0] ch;
    set_all(6'h3f, 2'b11, -16'sd300);
    for (int i = 0; i < 4; i++) begin
      ch = 6'(1 << i);
      drive_slot(ch, r_on, r_lr[i], r_pcm[i], 1'b1);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({pcm_l0, pcm_r0, snd0, pcm_l1, pcm_r1, snd1} !== 66'd0) begin
      errors++;
      $display("FAIL reset_mid: got l0=%h r0=%h l1=%h r1=%h required all 0",
               pcm_l0, pcm_r0, pcm_l1, pcm_r1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    last_l0 = '0; last_r0 = '0; last_l1 = '0; last_r1 = '0;
    // The aborted partial round must not publish at this ch0.
    set_all(6'h3f, 2'b10, 16'd250);
    run_round(6'b0, 1'b0);
  endtask

  // Includes non-one-hot cur_ch slots that must be ignored.
  task automatic test_shift();
    set_all(6'h3f, 2'b11, -16'sd2000);
    run_round(6'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    set_all(6'h3f, 2'b01, 16'd7);
    run_round(6'b0, 1'b0);
    set_all(6'h3f, 2'b10, -16'sd9);
    run_round(6'b0, 1'b0);
    drive_slot(6'b000001, 6'h3f, 2'b11, 16'd0, 1'b1);
    repeat (4) @(negedge clk);
    checks++;
    if (q0.size() != 0) begin
      errors++;
      $display("FAIL drain_dut0: pending=%0d required 0", q0.size());
    end
    checks++;
    if (q1.size() != 0) begin
      errors++;
      $display("FAIL drain_dut1: pending=%0d required 0", q1.size());
    end
  endtask

  initial begin
    test_reset();
    test_all_on();
    test_pan();
    test_sat();
    test_skip();
    test_reset_mid();
    test_shift();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
